// File: rtl/run_ctrl.sv
// Run-control sequencer: holds the core in reset-PC while start is high, launches on
// start falling, gates commits, and stops on a halt instruction or watchdog expiry.
//
// state | meaning
// IDLE  | after reset, waiting for the host to raise start
// LOAD  | start held high; PC forced to 0, counters and status cleared
// RUN   | executing; commits gated by halt_insn/stall
// DONE  | stopped; halt raised, counters and halt_pc frozen
module run_ctrl #(
    parameter int PC_W    = 10,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1048576
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             start,
    input  logic             halt_insn,
    input  logic             stall,
    input  logic [PC_W-1:0]  pc,
    output logic             pc_init,
    output logic             run_en,
    output logic             halt,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] insn_count,
    output logic [PC_W-1:0]  halt_pc
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t state, state_nxt;
    logic   wd_hit;

    assign wd_hit = (cycle_count == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: if (!start) state_nxt = RUN;
            RUN: begin
                if (start)          state_nxt = LOAD;
                else if (halt_insn) state_nxt = DONE;
                else if (wd_hit)    state_nxt = DONE;
            end
            DONE: if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // A restart request in RUN suppresses the in-flight commit.
    always_comb begin
        pc_init = (state == IDLE) || (state == LOAD);
        halt    = (state == DONE);
        run_en  = (state == RUN) && !start && !halt_insn && !stall;
    end

    // Status is cleared on entry to LOAD as well as while in it, so the host sees zeros
    // from the first LOAD cycle onward.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            cycle_count <= '0;
            insn_count  <= '0;
            halt_pc     <= '0;
            timeout     <= 1'b0;
        end else if (state == LOAD || state_nxt == LOAD) begin
            cycle_count <= '0;
            insn_count  <= '0;
            halt_pc     <= '0;
            timeout     <= 1'b0;
        end else if (state == RUN) begin
            if (cycle_count != CNT_MAX) cycle_count <= cycle_count + CNT_ONE;
            if (run_en && insn_count != CNT_MAX) insn_count <= insn_count + CNT_ONE;
            if (state_nxt == DONE) begin
                halt_pc <= pc;
                timeout <= !halt_insn;
            end
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with a short watchdog; a small fetch model supplies pc.
module tb_run_ctrl;

    logic        CLK = 1'b0;
    logic        Reset, start, halt_insn, stall;
    logic [9:0]  pc = '0;
    logic        pc_init, run_en, halt, timeout;
    logic [31:0] cycle_count, insn_count;
    logic [9:0]  halt_pc;

    int n_cmp = 0;
    int n_err = 0;

    run_ctrl #(.PC_W(10), .CNT_W(32), .TIMEOUT(16)) dut (
        .CLK(CLK), .Reset(Reset), .start(start), .halt_insn(halt_insn), .stall(stall),
        .pc(pc), .pc_init(pc_init), .run_en(run_en), .halt(halt), .timeout(timeout),
        .cycle_count(cycle_count), .insn_count(insn_count), .halt_pc(halt_pc)
    );

    always #5 CLK = ~CLK;

    // Fetch unit stand-in: PC clears under pc_init, advances on each commit.
    always @(posedge CLK) begin
        if (pc_init)     pc <= '0;
        else if (run_en) pc <= pc + 10'd1;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; halt_insn = 1'b0; stall = 1'b0;
        tick; tick;
        chk("rst_pc_init", 32'(pc_init), 32'd1);
        chk("rst_run_en", 32'(run_en), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_cycle", cycle_count, 32'd0);
        chk("rst_insn", insn_count, 32'd0);
        chk("rst_halt_pc", 32'(halt_pc), 32'd0);
        Reset = 1'b0;
        tick;
        chk("idle_pc_init", 32'(pc_init), 32'd1);

        // Basic run: halt on 5th RUN cycle
        start = 1'b1; tick; tick;
        chk("load_pc_init", 32'(pc_init), 32'd1);
        start = 1'b0; tick;
        chk("run1_run_en", 32'(run_en), 32'd1);
        chk("run1_pc_init", 32'(pc_init), 32'd0);
        chk("run1_pc", 32'(pc), 32'd0);
        repeat (4) tick;
        chk("run5_pc", 32'(pc), 32'd4);
        chk("run5_cycle", cycle_count, 32'd4);
        halt_insn = 1'b1; #1;
        chk("halt_cycle_run_en", 32'(run_en), 32'd0);
        tick;
        halt_insn = 1'b0;
        chk("t1_halt", 32'(halt), 32'd1);
        chk("t1_insn", insn_count, 32'd4);
        chk("t1_cycle", cycle_count, 32'd5);
        chk("t1_halt_pc", 32'(halt_pc), 32'd4);
        chk("t1_timeout", 32'(timeout), 32'd0);
        chk("t1_done_run_en", 32'(run_en), 32'd0);
        chk("t1_done_pc_init", 32'(pc_init), 32'd0);

        // One-cycle start pulse from DONE, then stall pattern run
        start = 1'b1; tick;
        chk("restart_halt", 32'(halt), 32'd0);
        chk("restart_pc_init", 32'(pc_init), 32'd1);
        start = 1'b0; tick;
        chk("rerun_cycle0", cycle_count, 32'd0);
        chk("rerun_insn0", insn_count, 32'd0);
        chk("rerun_halt_pc0", 32'(halt_pc), 32'd0);
        chk("rerun_pc_init", 32'(pc_init), 32'd0);
        for (int i = 0; i < 8; i++) begin
            stall = (i % 2 == 0);
            tick;
        end
        stall = 1'b1; halt_insn = 1'b1; tick;
        stall = 1'b0; halt_insn = 1'b0;
        chk("t2_halt", 32'(halt), 32'd1);
        chk("t2_insn", insn_count, 32'd4);
        chk("t2_cycle", cycle_count, 32'd9);
        chk("t2_halt_pc", 32'(halt_pc), 32'd4);

        // Watchdog expiry with no halt instruction
        start = 1'b1; tick;
        start = 1'b0; tick;
        repeat (15) tick;
        chk("t3_cycle15", cycle_count, 32'd15);
        chk("t3_run_en_last", 32'(run_en), 32'd1);
        chk("t3_halt_pre", 32'(halt), 32'd0);
        tick;
        chk("t3_halt", 32'(halt), 32'd1);
        chk("t3_timeout", 32'(timeout), 32'd1);
        chk("t3_cycle", cycle_count, 32'd16);
        chk("t3_insn", insn_count, 32'd16);
        chk("t3_halt_pc", 32'(halt_pc), 32'd15);
        tick;
        chk("t3_run_en_after", 32'(run_en), 32'd0);
        chk("t3_cycle_hold", cycle_count, 32'd16);

        // halt_insn coincides with watchdog terminal count
        start = 1'b1; tick;
        chk("t4_timeout_cleared", 32'(timeout), 32'd0);
        start = 1'b0; tick;
        repeat (15) tick;
        halt_insn = 1'b1; tick;
        halt_insn = 1'b0;
        chk("t4a_halt", 32'(halt), 32'd1);
        chk("t4a_timeout", 32'(timeout), 32'd0);
        chk("t4a_cycle", cycle_count, 32'd16);
        chk("t4a_insn", insn_count, 32'd15);
        chk("t4a_halt_pc", 32'(halt_pc), 32'd15);

        // halt_insn together with start: restart wins
        start = 1'b1; tick;
        start = 1'b0; tick;
        tick; tick;
        chk("t4b_pc", 32'(pc), 32'd2);
        halt_insn = 1'b1; start = 1'b1; #1;
        chk("t4b_run_en", 32'(run_en), 32'd0);
        tick;
        halt_insn = 1'b0;
        chk("t4b_halt", 32'(halt), 32'd0);
        chk("t4b_pc_init", 32'(pc_init), 32'd1);
        tick;
        chk("t4b_cycle", cycle_count, 32'd0);
        chk("t4b_insn", insn_count, 32'd0);
        chk("t4b_halt_pc", 32'(halt_pc), 32'd0);

        // Reset in the middle of RUN
        start = 1'b0; tick;
        tick; tick;
        chk("t6_cycle_pre", cycle_count, 32'd2);
        Reset = 1'b1; tick;
        chk("t6_pc_init", 32'(pc_init), 32'd1);
        chk("t6_run_en", 32'(run_en), 32'd0);
        chk("t6_halt", 32'(halt), 32'd0);
        chk("t6_cycle", cycle_count, 32'd0);
        chk("t6_insn", insn_count, 32'd0);
        Reset = 1'b0; tick; tick;
        chk("t6_idle_pc_init", 32'(pc_init), 32'd1);
        chk("t6_idle_halt", 32'(halt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run-control sequencer inside TopLevel. It answers the external start/halt handshake that a bench or host drives: it holds the core at PC 0 while start is high, and releases execution when start falls. It then gates per-cycle commit, and raises a sticky halt when the decoder reports a halt instruction or a watchdog expires. It also exports cycle and instruction counters plus the halting PC for post-run inspection.

## Interface
- PC_W, 10, width of program counter
- CNT_W, 32, width of cycle/instruction counters
- TIMEOUT, 1048576, RUN cycles allowed before forced stop (must be ≥2)

- CLK  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high reset
- start  in  1  level from host; high = load/hold, falling = launch
- halt_insn  in  1  decoder flags instruction at current PC as halt
- stall  in  1  core requests a bubble this cycle (no commit)
- pc  in  PC_W  current PC from fetch unit
- pc_init  out  1  forces PC to 0 and clears fetch state
- run_en  out  1  commit enable for PC update, reg_file and data_mem writes
- halt  out  1  sticky done flag to host
- timeout  out  1  sticky; set only when stop was caused by watchdog
- cycle_count  out  CNT_W  RUN cycles since last launch
- insn_count  out  CNT_W  committed instructions since last launch
- halt_pc  out  PC_W  PC of halt instruction (or PC at timeout)

## Operation
- States: IDLE, LOAD, RUN, DONE. Reset → IDLE.
- IDLE: pc_init=1, run_en=0. start=1 → LOAD; else stay.
- LOAD: pc_init=1, run_en=0, counters, halt_pc, halt and timeout cleared every cycle. start=0 → RUN; else stay.
- RUN: pc_init=0; run_en = !halt_insn && !stall.
  - cycle_count +1 every RUN cycle, including stall and halt cycles.
  - insn_count +1 on each cycle where run_en=1.
  - Priority, highest first:
    - start=1 → LOAD (restart; in-flight instruction not committed; run_en forced 0 that cycle).
    - halt_insn=1 → DONE, halt_pc←pc, timeout stays 0. The halt instruction is not counted. This applies even when stall=1.
    - cycle_count==TIMEOUT-1 → DONE, timeout←1, halt_pc←pc. The commit of that cycle still occurs if run_en=1.
- DONE: halt=1, run_en=0, pc_init=0 (PC frozen), all counters and halt_pc hold. start=1 → LOAD; else stay.
- halt = (state==DONE); pc_init = (state∈{IDLE,LOAD}). Both are decoded from the registered state, so they are glitch-free. run_en is the only combinational output (RUN-state AND inputs).
- Counters saturate at all-ones; they never wrap.
- Reset in any state, including mid-RUN: next cycle IDLE, all registers cleared, same cycle as Reset is sampled.

## Timing
- Reset values: pc_init=1, run_en=0, halt=0, timeout=0, cycle_count=0, insn_count=0, halt_pc=0.
- start sampled on CLK rising edge only; no edge detection beyond state.
- Launch latency: start sampled 0 at edge k in LOAD → RUN during cycle k+1; first instruction (PC 0) commits at edge k+1.
- Halt latency: halt_insn sampled 1 at edge m in RUN → halt=1 from cycle m+1 until start sampled 1.
- Restart: start sampled 1 in DONE at edge n → halt=0, pc_init=1 from cycle n+1.
- Minimum start pulse: one cycle high in IDLE/DONE is sufficient to reach LOAD.
- Watchdog: with no halt, DONE is entered after exactly TIMEOUT RUN cycles; then cycle_count==TIMEOUT.

## Test plan
- Reset then start=1 for 2 cycles, start=0: run_en=1 first RUN cycle, PC advances from 0; halt_insn at 5th RUN cycle → halt=1 next cycle, insn_count=4, cycle_count=5, halt_pc=pc value then, timeout=0.
- Stall pattern 1,0,1,0 during RUN for 8 cycles then halt_insn: insn_count=4, cycle_count=9.
- TIMEOUT=16, halt_insn never asserted: halt=1 and timeout=1 after 16 RUN cycles, cycle_count=16, run_en=0 afterwards.
- halt_insn and cycle_count==TIMEOUT-1 in same cycle: DONE with timeout=0; halt_insn with start=1 same cycle: LOAD, halt stays 0, counters cleared.
- In DONE, pulse start one cycle then low: halt drops, pc_init=1 one cycle, counters zero, second run counts independently.
- Reset asserted mid-RUN (cycle 3): next cycle IDLE, run_en=0, pc_init=1, all counters 0, halt never asserted.
